// File: rtl/pwm_code_averager.sv
// Block averager for discrete-PWM ADC duty codes: averages 2^LOG2_SAMPLES codes and
// publishes the rounded average, millivolts and block min/max over valid/ready.
module pwm_code_averager #(
  parameter int CODE_W        = 8,
  parameter int LOG2_SAMPLES  = 4,
  parameter int FULL_SCALE_MV = 3300,
  parameter int MV_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              sample_valid,
  input  logic [CODE_W-1:0] sample_code,
  output logic              avg_valid,
  input  logic              avg_ready,
  output logic [CODE_W-1:0] avg_code,
  output logic [MV_W-1:0]   avg_mv,
  output logic [CODE_W-1:0] min_code,
  output logic [CODE_W-1:0] max_code,
  output logic              overrun
);

  localparam int ACC_W  = CODE_W + LOG2_SAMPLES;
  localparam int PROD_W = CODE_W + $clog2(FULL_SCALE_MV + 1);
  localparam logic [LOG2_SAMPLES-1:0] LAST = '1;

  typedef enum logic [1:0] {IDLE, ARM, ACCUM} state_t;
  state_t state, state_nx;

  logic [ACC_W-1:0]        acc, acc_nx;
  logic [LOG2_SAMPLES-1:0] count;
  logic [CODE_W-1:0]       run_min, run_max, min_nx, max_nx;
  logic                    take, block_done;

  logic              s1_valid;
  logic [ACC_W-1:0]  s1_sum, sum_rnd;
  logic [CODE_W-1:0] s1_min, s1_max, avg_s1;
  logic [PROD_W-1:0] prod;
  logic [MV_W-1:0]   mv_s1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (enable) state_nx = ARM;
      ARM:     if (!enable) state_nx = IDLE;
               else if (sample_valid) state_nx = ACCUM;
      ACCUM:   if (!enable) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign take       = (state == ACCUM) && enable && sample_valid;
  assign block_done = take && (count == LAST);
  assign acc_nx     = acc + ACC_W'(sample_code);
  // First sample of each block seeds the running extremes.
  assign min_nx = ((count == '0) || (sample_code < run_min)) ? sample_code : run_min;
  assign max_nx = ((count == '0) || (sample_code > run_max)) ? sample_code : run_max;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc     <= '0;
      count   <= '0;
      run_min <= '0;
      run_max <= '0;
    end else if (state != ACCUM || !enable || block_done) begin
      acc     <= '0;
      count   <= '0;
      run_min <= '0;
      run_max <= '0;
    end else if (take) begin
      acc     <= acc_nx;
      count   <= count + 1'b1;
      run_min <= min_nx;
      run_max <= max_nx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_min   <= '0;
      s1_max   <= '0;
    end else begin
      s1_valid <= block_done;
      if (block_done) begin
        s1_sum <= acc_nx;
        s1_min <= min_nx;
        s1_max <= max_nx;
      end
    end
  end

  assign sum_rnd = s1_sum + ACC_W'(1 << (LOG2_SAMPLES - 1));
  assign avg_s1  = CODE_W'(sum_rnd >> LOG2_SAMPLES);
  assign prod    = PROD_W'(avg_s1) * PROD_W'(FULL_SCALE_MV);
  assign mv_s1   = MV_W'(prod >> CODE_W);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      avg_valid <= 1'b0;
      avg_code  <= '0;
      avg_mv    <= '0;
      min_code  <= '0;
      max_code  <= '0;
      overrun   <= 1'b0;
    end else begin
      if (s1_valid) begin
        avg_valid <= 1'b1;
        avg_code  <= avg_s1;
        avg_mv    <= mv_s1;
        min_code  <= s1_min;
        max_code  <= s1_max;
      end else if (avg_valid && avg_ready) begin
        avg_valid <= 1'b0;
      end
      // Disable clears the sticky flag even if an overwrite lands on the same edge.
      if (!enable)
        overrun <= 1'b0;
      else if (s1_valid && avg_valid && !avg_ready)
        overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pwm_code_averager.sv
// Scoreboard bench for pwm_code_averager: block results are predicted when samples
// are driven and compared when the DUT hands a result over.
module tb_pwm_code_averager;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       sample_valid = 1'b0;
  logic [7:0] sample_code = '0;
  logic       avg_valid;
  logic       avg_ready = 1'b0;
  logic [7:0] avg_code, min_code, max_code;
  logic [15:0] avg_mv;
  logic       overrun;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct { int code; int mv; int mn; int mx; } exp_t;
  exp_t sb[$];

  pwm_code_averager #(.CODE_W(8), .LOG2_SAMPLES(4), .FULL_SCALE_MV(3300), .MV_W(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .sample_valid(sample_valid),
    .sample_code(sample_code), .avg_valid(avg_valid), .avg_ready(avg_ready),
    .avg_code(avg_code), .avg_mv(avg_mv), .min_code(min_code), .max_code(max_code),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Handshake completes on the following rising edge.
  always @(negedge clk) begin
    if (rst && avg_valid && avg_ready) begin
      if (sb.size() == 0) begin
        check("spurious_valid", int'(avg_valid), 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("avg_code", int'(avg_code), e.code);
        check("avg_mv", int'(avg_mv), e.mv);
        check("min_code", int'(min_code), e.mn);
        check("max_code", int'(max_code), e.mx);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input int code, input int gap_max);
    repeat ($urandom_range(0, gap_max)) tick();
    sample_code  = 8'(code);
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic start();
    enable = 1'b0;
    tick(); tick();
    enable = 1'b1;
    tick();
    send(int'($urandom_range(0, 255)), 2);
  endtask

  // mode 0: constant a; 1: alternating a/b; 2: random in [a,b]
  task automatic send_block(input int mode, input int a, input int b, input int gap_max,
                            input int n);
    int sum = 0, mn = 255, mx = 0, v;
    exp_t e;
    for (int i = 0; i < n; i++) begin
      v = (mode == 0) ? a : (mode == 1) ? ((i % 2) ? b : a) : int'($urandom_range(a, b));
      sum += v;
      if (v < mn) mn = v;
      if (v > mx) mx = v;
      send(v, gap_max);
    end
    if (n == 16) begin
      e.code = (sum + 8) / 16;
      e.mv   = (e.code * 3300) / 256;
      e.mn   = mn;
      e.mx   = mx;
      sb.push_back(e);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain", sb.size(), 0);
    tick();
  endtask

  initial begin
    #3;
    check("rst_avg_valid", int'(avg_valid), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_min", int'(min_code), 0);
    check("rst_max", int'(max_code), 0);
    check("rst_code", int'(avg_code), 0);
    tick();
    rst = 1'b1;
    avg_ready = 1'b1;

    // Constant 100 at random spacing, plus latency/pulse width.
    start();
    send_block(0, 100, 0, 3, 16);
    check("lat_t0", int'(avg_valid), 0);
    tick();
    check("lat_t1", int'(avg_valid), 1);
    check("t1_code", int'(avg_code), 100);
    check("t1_mv", int'(avg_mv), 1289);
    tick();
    check("lat_t2", int'(avg_valid), 0);
    wait_drain(50);

    // Alternating extremes.
    start();
    send_block(1, 0, 255, 2, 16);
    wait_drain(50);

    // Back-to-back full scale, two blocks with no gap.
    start();
    send_block(0, 255, 0, 0, 16);
    send_block(0, 255, 0, 0, 16);
    wait_drain(50);
    check("b2b_overrun", int'(overrun), 0);
    check("b2b_idle", int'(avg_valid), 0);

    // Overrun: consumer stalled across two blocks.
    avg_ready = 1'b0;
    start();
    send_block(0, 10, 0, 1, 16);
    send_block(0, 20, 0, 1, 16);
    repeat (4) tick();
    check("ovr_valid", int'(avg_valid), 1);
    check("ovr_code", int'(avg_code), 20);
    check("ovr_mv", int'(avg_mv), 257);
    check("ovr_flag", int'(overrun), 1);
    void'(sb.pop_front());
    avg_ready = 1'b1;
    tick();
    check("ovr_accept", int'(avg_valid), 0);
    check("ovr_sticky", int'(overrun), 1);
    check("ovr_drained", sb.size(), 0);
    enable = 1'b0;
    tick();
    check("ovr_clear", int'(overrun), 0);

    // Partial block discarded on disable.
    start();
    send_block(0, 77, 0, 1, 8);
    enable = 1'b0;
    repeat (3) tick();
    enable = 1'b1;
    tick();
    send(int'($urandom_range(0, 255)), 1);
    send_block(0, 50, 0, 1, 16);
    wait_drain(50);
    repeat (3) tick();
    check("partial_idle", int'(avg_valid), 0);

    // Async reset mid-block while a result is held.
    avg_ready = 1'b0;
    start();
    send_block(0, 30, 0, 1, 16);
    send_block(0, 40, 0, 1, 5);
    check("pre_rst_valid", int'(avg_valid), 1);
    #3;
    rst = 1'b0;
    #1;
    check("arst_valid", int'(avg_valid), 0);
    check("arst_code", int'(avg_code), 0);
    check("arst_mv", int'(avg_mv), 0);
    check("arst_min", int'(min_code), 0);
    check("arst_max", int'(max_code), 0);
    sb.delete();
    enable = 1'b0;
    tick();
    rst = 1'b1;
    avg_ready = 1'b1;
    start();
    send_block(2, 0, 255, 2, 16);
    wait_drain(50);
    check("post_rst_overrun", int'(overrun), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pwm_code_averager.md
# pwm_code_averager

Block-averaging post-processor for the discrete-PWM ADC. It sits directly downstream of the PWM/sawtooth stage. It consumes the 8-bit duty-cycle code latched at each comparator falling edge and averages 2^LOG2_SAMPLES codes. It publishes the rounded average, a millivolt conversion and the block min/max over a valid/ready handshake to the display/readout logic.

## Interface
- CODE_W, 8: width of incoming duty-cycle code.
- LOG2_SAMPLES, 4: log2 of codes per block (16 by default), legal 1..8.
- FULL_SCALE_MV, 3300: millivolts represented by code 2^CODE_W.
- MV_W, 16: width of millivolt output.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  level; 1 = averaging active.
- sample_valid  in  1  one-cycle strobe, driven by the falling-edge detector output.
- sample_code  in  CODE_W  duty-cycle code, valid when sample_valid=1.
- avg_valid  out  1  result available.
- avg_ready  in  1  consumer accepts the result when avg_valid & avg_ready at a rising edge.
- avg_code  out  CODE_W  rounded block average.
- avg_mv  out  MV_W  (avg_code*FULL_SCALE_MV) >> CODE_W, truncated.
- min_code / max_code  out  CODE_W  extremes of the block.
- overrun  out  1  sticky flag: an unaccepted result was overwritten.

## Operation
- Reset value of every output and internal register is 0. This includes avg_valid, overrun, min_code and max_code.
- FSM states:
  - IDLE: accumulator, count and running min/max held cleared.
  - IDLE -> ARM when enable=1.
  - ARM: discards the first sample_valid after enable, because that PWM period is partial.
  - ARM -> ACCUM on that discarded sample.
  - ACCUM: each sample_valid adds sample_code to acc (width CODE_W+LOG2_SAMPLES), increments count, and updates running min/max.
  - Running min initialises to the first sample of each block, not 0.
- Block completion happens on the sample_valid where count = 2^LOG2_SAMPLES-1. On that edge:
  - acc+sample_code, final min and final max are copied to the stage-1 registers and stage1_valid is set.
  - acc and count clear, and the FSM stays in ACCUM.
  - No sample is lost between blocks.
- Stage 1 (one cycle):
  - avg = (sum + 2^(LOG2_SAMPLES-1)) >> LOG2_SAMPLES.
  - The maximum is 255 for CODE_W=8, so no saturation is needed.
  - mv = (avg*FULL_SCALE_MV) >> CODE_W, using a full-width product.
- Output register: loads avg/mv/min/max from stage 1 and sets avg_valid.
- Handshake:
  - avg_valid=1 together with avg_ready=1 clears avg_valid, unless a new stage-1 result loads on the same edge. In that case the new result loads and avg_valid stays 1.
  - Outputs stay stable while avg_valid=1 and avg_ready=0, except on overrun.
- Overrun: stage 1 completes while avg_valid=1 and avg_ready=0. The new result overwrites the outputs, avg_valid stays 1 and overrun sets. overrun clears only on rst or when enable=0.
- enable=0 mid-block:
  - The FSM returns to IDLE next edge and the partial block is discarded.
  - An in-flight stage-1 result still completes.
  - An already-valid output remains until accepted.
- sample_valid is ignored in IDLE.
- Asynchronous rst assertion at any time returns everything to reset values immediately.

## Timing
- Block-completing sample at edge T gives stage1_valid at T. avg_valid=1 after edge T+1, so latency is 2 clocks.
- Back-to-back sample_valid on consecutive cycles is supported; throughput is 1 sample/clock.
- Acceptance at edge A: avg_valid low after A if no new load occurs at A.
- enable 0->1 at edge E: state ARM after E. The first sample at or after E+1 is discarded.
- The input path is combinational only into registers; there is no combinational path from avg_ready to any output.

## Test plan
- Enable, 1 discard + 16 samples of 100 at random spacing, avg_ready=1 -> avg_code=100, avg_mv=1289, min=max=100, avg_valid pulses 1 cycle, 2 clocks after the 16th strobe.
- 16 samples alternating 0/255 -> avg_code=128, avg_mv=1650, min_code=0, max_code=255.
- 16 samples of 255 on consecutive cycles, then 16 more immediately -> two results each avg_code=255, avg_mv=3287, no dropped sample, overrun=0.
- avg_ready held 0 across two complete blocks (values 10 then 20) -> avg_valid stays 1, avg_code=20, overrun=1. Raise avg_ready -> avg_valid falls next edge; overrun stays 1 until enable=0.
- 8 samples, then enable=0, then re-enable with 1 discard + 16 samples of 50 -> no result from the partial block, single result avg_code=50.
- rst asserted asynchronously mid-block with avg_valid=1 -> all outputs 0 immediately. After release and enable, the first block completes normally.
